// File: rtl/fifo_top.sv
// 16x8 single-clock FIFO with first-word-fall-through output.
// Flags: empty, full, threshold, and sticky overflow/underflow.
module fifo_top #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int THRESHOLD  = 8
) (
    input  logic                  rdEn,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_threshold,
    output logic                  fifo_empty,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow,
    output logic                  fifo_full,
    input  logic                  reset,
    input  logic                  clk
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   occupancy;
    logic                  we;
    logic                  re;

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign occupancy      = wr_ptr - rd_ptr;
    assign fifo_empty     = (wr_ptr == rd_ptr);
    assign fifo_full      = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                            (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign fifo_threshold = (occupancy >= (ADDR_WIDTH + 1)'(THRESHOLD));

    assign we       = wrEn & ~fifo_full;
    assign re       = rdEn & ~fifo_empty;
    assign data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // NOTE: storage is reset along with the pointers so data_out reads 0 after
    // reset; this costs a reset net on every bit but is required behaviour here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (we) wr_ptr <= wr_ptr + 1'b1;
            if (re) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky error flags: a new offending request outranks a same-edge clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            if (wrEn && fifo_full)       fifo_overflow <= 1'b1;
            else if (re)                 fifo_overflow <= 1'b0;

            if (rdEn && fifo_empty)      fifo_underflow <= 1'b1;
            else if (we)                 fifo_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_top.sv
// Scoreboard bench for fifo_top: stimulus queues expected words, a monitor
// compares data_out on every accepted pop; flags are checked directly.
module tb_fifo_top;

    logic       clk = 1'b0;
    logic       reset;
    logic       rdEn, wrEn;
    logic [7:0] data_in, data_out;
    logic       fifo_threshold, fifo_empty, fifo_overflow, fifo_underflow, fifo_full;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] exp_q[$];

    fifo_top dut (
        .rdEn(rdEn), .wrEn(wrEn), .data_in(data_in), .data_out(data_out),
        .fifo_threshold(fifo_threshold), .fifo_empty(fifo_empty),
        .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
        .fifo_full(fifo_full), .reset(reset), .clk(clk)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Inputs change 1 time unit after the rising edge; flags are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wrEn = 1'b0;
        rdEn = 1'b0;
    endtask

    task automatic push_words(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wrEn = 1'b1;
            data_in = base + 8'(i);
            exp_q.push_back(base + 8'(i));
            tick();
        end
        idle();
    endtask

    task automatic pop_words(input int n);
        for (int i = 0; i < n; i++) begin
            rdEn = 1'b1;
            tick();
        end
        idle();
    endtask

    // Monitor: a pop is accepted at the next edge when rdEn is high and not empty.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && rdEn && !fifo_empty) begin
                if (exp_q.size() == 0) check("pop_without_expected", 32'(data_out), 32'hFFFF_FFFF);
                else check("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        idle();
        data_in = 8'h00;
        tick();
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_thr", 32'(fifo_threshold), 0);
        check("rst_ovf", 32'(fifo_overflow), 0);
        check("rst_udf", 32'(fifo_underflow), 0);
        check("rst_data", 32'(data_out), 0);
        reset = 1'b1;
        tick();

        // Fill with 0x01..0x11; the 17th write is dropped.
        for (int i = 1; i <= 17; i++) begin
            wrEn = 1'b1;
            data_in = 8'(i);
            if (i <= 16) exp_q.push_back(8'(i));
            tick();
            check($sformatf("fill_thr_%0d", i), 32'(fifo_threshold), (i >= 8) ? 1 : 0);
            check($sformatf("fill_full_%0d", i), 32'(fifo_full), (i >= 16) ? 1 : 0);
            check($sformatf("fill_ovf_%0d", i), 32'(fifo_overflow), (i == 17) ? 1 : 0);
        end
        idle();
        check("fill_head", 32'(data_out), 32'h01);

        // Drain 17: first pop clears overflow, last read underflows.
        for (int i = 1; i <= 17; i++) begin
            rdEn = 1'b1;
            tick();
            if (i == 1) check("drain_ovf_clear", 32'(fifo_overflow), 0);
            if (i == 16) check("drain_empty16", 32'(fifo_empty), 1);
            if (i >= 16) check($sformatf("drain_data_hold_%0d", i), 32'(data_out), 32'h01);
            check($sformatf("drain_udf_%0d", i), 32'(fifo_underflow), (i == 17) ? 1 : 0);
        end
        idle();

        // Sticky underflow clears on the next accepted write.
        push_words(8'hA5, 1);
        check("sticky_udf_clear", 32'(fifo_underflow), 0);
        check("sticky_not_empty", 32'(fifo_empty), 0);
        check("sticky_head", 32'(data_out), 32'hA5);
        pop_words(1);
        check("sticky_drained", 32'(fifo_empty), 1);

        // Wrap: four rounds of 10 writes then 10 reads.
        for (int r = 0; r < 4; r++) begin
            push_words(8'h20 + 8'(r * 16), 10);
            check($sformatf("wrap_thr_%0d", r), 32'(fifo_threshold), 1);
            pop_words(10);
            check($sformatf("wrap_empty_%0d", r), 32'(fifo_empty), 1);
        end

        // Simultaneous read/write at occupancy 5.
        push_words(8'h40, 5);
        for (int i = 0; i < 3; i++) begin
            wrEn = 1'b1;
            rdEn = 1'b1;
            data_in = 8'h45 + 8'(i);
            exp_q.push_back(8'h45 + 8'(i));
            tick();
        end
        idle();
        check("simul_head", 32'(data_out), 32'h43);
        pop_words(4);
        check("simul_occ_not_empty", 32'(fifo_empty), 0);
        pop_words(1);
        check("simul_occ_empty", 32'(fifo_empty), 1);

        // Both high while full: only the read happens.
        push_words(8'h50, 16);
        check("full_before", 32'(fifo_full), 1);
        wrEn = 1'b1;
        rdEn = 1'b1;
        data_in = 8'h60;
        tick();
        idle();
        check("full_both_full", 32'(fifo_full), 0);
        check("full_both_ovf", 32'(fifo_overflow), 1);
        check("full_both_thr", 32'(fifo_threshold), 1);
        check("full_both_head", 32'(data_out), 32'h51);
        pop_words(1);
        check("full_both_ovf_clear", 32'(fifo_overflow), 0);
        pop_words(14);
        check("full_both_drained", 32'(fifo_empty), 1);

        // Both high while empty: only the write happens.
        wrEn = 1'b1;
        rdEn = 1'b1;
        data_in = 8'h70;
        exp_q.push_back(8'h70);
        tick();
        idle();
        check("empty_both_empty", 32'(fifo_empty), 0);
        check("empty_both_udf", 32'(fifo_underflow), 1);
        check("empty_both_head", 32'(data_out), 32'h70);
        pop_words(1);
        check("empty_both_occ1", 32'(fifo_empty), 1);

        // Mid-run reset discards contents immediately.
        for (int i = 0; i < 3; i++) begin
            wrEn = 1'b1;
            data_in = 8'h80 + 8'(i);
            tick();
        end
        idle();
        check("pre_rst_head", 32'(data_out), 32'h80);
        reset = 1'b0;
        #1;
        check("midrst_data", 32'(data_out), 0);
        check("midrst_empty", 32'(fifo_empty), 1);
        check("midrst_udf", 32'(fifo_underflow), 0);
        check("midrst_ovf", 32'(fifo_overflow), 0);
        tick();
        reset = 1'b1;
        tick();
        push_words(8'h99, 1);
        check("post_rst_head", 32'(data_out), 32'h99);
        pop_words(1);
        check("post_rst_empty", 32'(fifo_empty), 1);

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
